// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: divider state encoding and constants.
package cpu_defs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int          DIV_ITER      = 32;
  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the execute stage.
// Holds its result until the instruction leaves E; aborts on an E flush.
module div_unit
  import cpu_defs_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             cancel,
  input  logic             e_advance,
  output logic             stall_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o
);

  localparam logic [5:0] LAST = 6'(DIV_ITER - 1);

  div_state_t       state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             drain_q, drain_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] dvd_nx;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;

  always_comb begin
    shifted = {rem_q, dvd_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
    q_bit   = ~diff[WIDTH];
    rem_nx  = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    dvd_nx  = {dvd_q[WIDTH-2:0], q_bit};
    a_abs   = (is_signed && opa[WIDTH-1]) ? -opa : opa;
    b_abs   = (is_signed && opb[WIDTH-1]) ? -opb : opb;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    quot_d  = quot_q;
    res_d   = res_q;
    drain_d = drain_q;

    unique case (state_q)
      IDLE: begin
        drain_d = 1'b0;
        // The cycle right after DONE is a dead cycle for the next divide.
        if (start && !drain_q) begin
          if (opb == '0) begin
            quot_d  = WIDTH'(DIV_ZERO_QUOT);
            res_d   = opa;
            state_d = DONE;
          end else begin
            rem_d   = '0;
            dvd_d   = a_abs;
            dvs_d   = b_abs;
            qneg_d  = is_signed & (opa[WIDTH-1] ^ opb[WIDTH-1]);
            rneg_d  = is_signed & opa[WIDTH-1];
            cnt_d   = '0;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        rem_d = rem_nx;
        dvd_d = dvd_nx;
        cnt_d = cnt_q + 6'd1;
        if (!start) begin
          state_d = IDLE;
        end else if (cnt_q == LAST) begin
          quot_d  = qneg_q ? -dvd_nx : dvd_nx;
          res_d   = rneg_q ? -rem_nx : rem_nx;
          state_d = DONE;
        end
      end
      DONE: begin
        if (e_advance) begin
          state_d = IDLE;
          drain_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (cancel) begin
      state_d = IDLE;
      drain_d = 1'b0;
      quot_d  = quot_q;
      res_d   = res_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      quot_q  <= '0;
      res_q   <= '0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      quot_q  <= quot_d;
      res_q   <= res_d;
      drain_q <= drain_d;
    end
  end

  assign stall_o = start & (state_q != DONE) & ~cancel & ~rst;
  assign valid_o = (state_q == DONE);
  assign quot_o  = quot_q;
  assign rem_o   = res_q;

  a_start_held: assert property (
    @(posedge clk) disable iff (rst)
    (state_q == BUSY) |-> (start || cancel)
  );

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus randomized
// divides against an arithmetic reference model.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        cancel;
  logic        e_advance;
  logic        stall_o;
  logic        valid_o;
  logic [31:0] quot_o;
  logic [31:0] rem_o;

  int checks = 0;
  int errors = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .is_signed(is_signed),
    .opa      (opa),
    .opb      (opb),
    .cancel   (cancel),
    .e_advance(e_advance),
    .stall_o  (stall_o),
    .valid_o  (valid_o),
    .quot_o   (quot_o),
    .rem_o    (rem_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic ref_div(input logic s, input logic [31:0] a,
                         input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
    longint la, lb, lq, lr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s) begin
      la = longint'($signed(a));
      lb = longint'($signed(b));
      lq = la / lb;
      lr = la % lb;
      q  = lq[31:0];
      r  = lr[31:0];
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  // Drives one divide and counts stall cycles until valid_o rises.
  task automatic do_div(input string tag, input logic s,
                        input logic [31:0] a, input logic [31:0] b,
                        input int exp_st);
    logic [31:0] eq, er;
    int st;
    bit done;
    ref_div(s, a, b, eq, er);
    start = 1'b1;
    is_signed = s;
    opa = a;
    opb = b;
    st = 0;
    done = 0;
    for (int i = 0; i < 120; i++) begin
      #1;
      if (st > 0 && valid_o) begin
        done = 1;
        break;
      end
      if (stall_o) st++;
      @(posedge clk);
      #1;
      if (i == 0) e_advance = 1'b0;
    end
    chk({tag, "_valid"}, 32'(done), 32'd1);
    chk({tag, "_stall"}, st, exp_st);
    chk({tag, "_quot"}, quot_o, eq);
    chk({tag, "_rem"}, rem_o, er);
  endtask

  task automatic release_e();
    start = 1'b0;
    e_advance = 1'b1;
    @(posedge clk);
    #1;
    e_advance = 1'b0;
    @(posedge clk);
    #1;
    chk("release_valid", 32'(valid_o), 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb, hq, hr;
    logic        rs;
    int          rises;
    rst = 1'b1;
    start = 1'b0;
    is_signed = 1'b0;
    opa = '0;
    opb = '0;
    cancel = 1'b0;
    e_advance = 1'b0;
    #2;
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_quot", quot_o, 32'd0);
    chk("rst_rem", rem_o, 32'd0);
    #10 rst = 1'b0;
    @(posedge clk);
    #1;

    do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 33);
    release_e();
    do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33);
    chk("div_m7_2_qlit", quot_o, 32'hFFFF_FFFD);
    chk("div_m7_2_rlit", rem_o, 32'hFFFF_FFFF);
    release_e();
    do_div("divu_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 33);
    chk("divu_m7_2_qlit", quot_o, 32'h7FFF_FFFC);
    release_e();
    do_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33);
    chk("div_ovf_qlit", quot_o, 32'h8000_0000);
    release_e();
    do_div("divu_5_0", 1'b0, 32'd5, 32'd0, 1);
    release_e();
    do_div("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 1);
    release_e();

    // Flush in cycle 10 of BUSY
    start = 1'b1;
    is_signed = 1'b0;
    opa = 32'd12345;
    opb = 32'd11;
    repeat (10) @(posedge clk);
    #1;
    cancel = 1'b1;
    #1;
    chk("cancel_stall", 32'(stall_o), 32'd0);
    @(posedge clk);
    #1;
    cancel = 1'b0;
    start = 1'b0;
    rises = 0;
    repeat (40) begin
      #1;
      if (valid_o) rises++;
      @(posedge clk);
      #1;
    end
    chk("cancel_no_valid", rises, 0);
    do_div("divu_9_3", 1'b0, 32'd9, 32'd3, 33);
    release_e();

    // Start blocked by a simultaneous flush in IDLE
    start = 1'b1;
    cancel = 1'b1;
    opa = 32'd50;
    opb = 32'd0;
    #1;
    chk("idle_cancel_stall", 32'(stall_o), 32'd0);
    @(posedge clk);
    #1;
    chk("idle_cancel_valid", 32'(valid_o), 32'd0);
    start = 1'b0;
    cancel = 1'b0;
    @(posedge clk);
    #1;

    // Hold in DONE, then back-to-back
    do_div("hold", 1'b1, 32'hFFFF_FC18, 32'd7, 33);
    ref_div(1'b1, 32'hFFFF_FC18, 32'd7, hq, hr);
    rises = 0;
    repeat (5) begin
      @(posedge clk);
      #2;
      if (!valid_o || stall_o || quot_o !== hq || rem_o !== hr) rises++;
    end
    chk("hold_stable", rises, 0);
    e_advance = 1'b1;
    do_div("b2b_1000_10", 1'b0, 32'd1000, 32'd10, 34);
    release_e();

    for (int n = 0; n < 24; n++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'hFFFF_FFFF;
        3: ra = 32'h8000_0000;
        default: rb = $urandom;
      endcase
      if (ra == 32'h8000_0000 && rb == 32'd0) rb = 32'd3;
      do_div($sformatf("rnd%0d", n), rs, ra, rb, (rb == 0) ? 1 : 33);
      release_e();
    end

    // Async reset between edges during BUSY
    do_div("pre_rst", 1'b0, 32'd77, 32'd5, 33);
    release_e();
    start = 1'b1;
    is_signed = 1'b0;
    opa = 32'd100;
    opb = 32'd7;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_quot", quot_o, 32'd0);
    chk("arst_rem", rem_o, 32'd0);
    chk("arst_valid", 32'(valid_o), 32'd0);
    chk("arst_stall", 32'(stall_o), 32'd0);
    start = 1'b0;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    do_div("post_rst", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 33);
    release_e();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
